// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the data-memory access unit.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } access_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BEAT0 = 2'b01,
        BEAT1 = 2'b10,
        RESP  = 2'b11
    } mem_state_t;

    // Byte-lane mask of an access starting at lane 0.
    function automatic logic [3:0] size_mask(input access_size_t size);
        case (size)
            SIZE_BYTE: return 4'b0001;
            SIZE_HALF: return 4'b0011;
            SIZE_WORD: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    // Number of bytes touched by an access; 0 for the illegal encoding.
    function automatic logic [2:0] size_bytes(input access_size_t size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts and extends load data from a two-word read window.
module load_align
    import mem_access_pkg::*;
(
    input  logic [63:0]  window,
    input  logic [1:0]   off,
    input  access_size_t size,
    input  logic         is_unsigned,
    output logic [31:0]  data
);

    logic [31:0] shifted;

    assign shifted = 32'(window >> {off, 3'b000});

    // Truncate to the access size and sign/zero-extend.
    always_comb begin
        data = shifted;
        case (size)
            SIZE_BYTE: data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default:   data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-organised data memory.
// Optional feature macro: MEM_ACCESS_MISALIGNED_SPLIT_EN (word-crossing
// accesses run as two beats; without it they fault at accept).
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADRESS_SIZE       = 32,
    parameter int unsigned MEMORY_SIZE_WORDS = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ReqValid,
    output logic                   ReqReady,
    input  logic                   ReqWrite,
    input  logic [1:0]             ReqSize,
    input  logic                   ReqUnsigned,
    input  logic [ADRESS_SIZE-1:0] ReqAddr,
    input  logic [31:0]            ReqWData,
    output logic                   RespValid,
    input  logic                   RespReady,
    output logic [31:0]            RespData,
    output logic                   RespFault,
    output logic                   MemEn,
    output logic                   WriteEnable,
    output logic [3:0]             ByteEn,
    output logic [ADRESS_SIZE-1:0] MemoryAdress,
    output logic [31:0]            InputData,
    input  logic [31:0]            MemData
);

    localparam int unsigned AW = ADRESS_SIZE;
    localparam logic [AW:0] MEM_BYTES = (AW + 1)'(4 * MEMORY_SIZE_WORDS);

    mem_state_t   state;
    logic [1:0]   off_q;
    access_size_t size_q;
    logic         unsigned_q;
    logic         write_q;

    access_size_t req_size;
    logic [1:0]   req_off;
    logic [2:0]   req_bytes;
    logic [AW:0]  req_last;
    logic         req_cross;
    logic         req_fault;
    logic [63:0]  window;
    logic [31:0]  load_data;

    assign req_size  = access_size_t'(ReqSize);
    assign req_off   = ReqAddr[1:0];
    assign req_bytes = size_bytes(req_size);
    assign req_last  = {1'b0, ReqAddr} + (AW + 1)'(req_bytes) - (AW + 1)'(1);
    assign req_cross = (3'(req_off) + req_bytes) > 3'd4;

`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
    logic         cross_q;
    logic [3:0]   hi_be_q;
    logic [31:0]  hi_data_q;
    logic [31:0]  beat0_q;
    logic [7:0]   req_m8;
    logic [63:0]  req_lanes;

    assign req_m8    = 8'({4'b0000, size_mask(req_size)} << req_off);
    assign req_lanes = {32'h0, ReqWData} << {req_off, 3'b000};
    assign req_fault = (req_size == SIZE_ILLEGAL) || req_last[AW] || (req_last >= MEM_BYTES);
    assign window    = (state == BEAT1) ? {MemData, beat0_q} : {32'h0, MemData};
`else
    logic [3:0]   req_m8;
    logic [31:0]  req_lanes;

    assign req_m8    = size_mask(req_size) << req_off;
    assign req_lanes = ReqWData << {req_off, 3'b000};
    assign req_fault = (req_size == SIZE_ILLEGAL) || req_last[AW] || (req_last >= MEM_BYTES)
                       || req_cross;
    assign window    = {32'h0, MemData};
`endif

    load_align u_load_align (
        .window      (window),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .data        (load_data)
    );

    // Access FSM with registered memory-port and handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            off_q        <= 2'b00;
            size_q       <= SIZE_BYTE;
            unsigned_q   <= 1'b0;
            write_q      <= 1'b0;
            ReqReady     <= 1'b0;
            RespValid    <= 1'b0;
            RespData     <= 32'h0;
            RespFault    <= 1'b0;
            MemEn        <= 1'b0;
            WriteEnable  <= 1'b0;
            ByteEn       <= 4'b0000;
            MemoryAdress <= '0;
            InputData    <= 32'h0;
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
            cross_q      <= 1'b0;
            hi_be_q      <= 4'b0000;
            hi_data_q    <= 32'h0;
            beat0_q      <= 32'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ReqReady <= 1'b1;
                    if (ReqValid && ReqReady) begin
                        ReqReady   <= 1'b0;
                        off_q      <= req_off;
                        size_q     <= req_size;
                        unsigned_q <= ReqUnsigned;
                        write_q    <= ReqWrite;
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
                        cross_q    <= req_cross;
                        hi_be_q    <= req_m8[7:4];
                        hi_data_q  <= req_lanes[63:32];
`endif
                        if (req_fault) begin
                            state     <= RESP;
                            RespValid <= 1'b1;
                            RespFault <= 1'b1;
                            RespData  <= 32'h0;
                        end else begin
                            state        <= BEAT0;
                            MemEn        <= 1'b1;
                            WriteEnable  <= ReqWrite;
                            MemoryAdress <= {ReqAddr[AW-1:2], 2'b00};
                            ByteEn       <= req_m8[3:0];
                            InputData    <= req_lanes[31:0];
                        end
                    end
                end
                BEAT0: begin
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
                    if (cross_q) begin
                        state        <= BEAT1;
                        beat0_q      <= MemData;
                        MemoryAdress <= MemoryAdress + AW'(4);
                        ByteEn       <= hi_be_q;
                        InputData    <= hi_data_q;
                    end else
`endif
                    begin
                        state        <= RESP;
                        MemEn        <= 1'b0;
                        WriteEnable  <= 1'b0;
                        ByteEn       <= 4'b0000;
                        MemoryAdress <= '0;
                        InputData    <= 32'h0;
                        RespValid    <= 1'b1;
                        RespFault    <= 1'b0;
                        RespData     <= write_q ? 32'h0 : load_data;
                    end
                end
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
                BEAT1: begin
                    state        <= RESP;
                    MemEn        <= 1'b0;
                    WriteEnable  <= 1'b0;
                    ByteEn       <= 4'b0000;
                    MemoryAdress <= '0;
                    InputData    <= 32'h0;
                    RespValid    <= 1'b1;
                    RespFault    <= 1'b0;
                    RespData     <= write_q ? 32'h0 : load_data;
                end
`endif
                RESP: begin
                    if (RespReady) begin
                        state     <= IDLE;
                        RespValid <= 1'b0;
                        RespData  <= 32'h0;
                        RespFault <= 1'b0;
                        ReqReady  <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    MemEn        <= 1'b0;
                    WriteEnable  <= 1'b0;
                    ByteEn       <= 4'b0000;
                    MemoryAdress <= '0;
                    InputData    <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small vector-storage model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ReqValid, ReqReady, ReqWrite, ReqUnsigned;
    logic [1:0]  ReqSize;
    logic [31:0] ReqAddr, ReqWData;
    logic        RespValid, RespReady, RespFault;
    logic [31:0] RespData;
    logic        MemEn, WriteEnable;
    logic [3:0]  ByteEn;
    logic [31:0] MemoryAdress, InputData, MemData;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADRESS_SIZE(32), .MEMORY_SIZE_WORDS(1024)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ReqValid     (ReqValid),
        .ReqReady     (ReqReady),
        .ReqWrite     (ReqWrite),
        .ReqSize      (ReqSize),
        .ReqUnsigned  (ReqUnsigned),
        .ReqAddr      (ReqAddr),
        .ReqWData     (ReqWData),
        .RespValid    (RespValid),
        .RespReady    (RespReady),
        .RespData     (RespData),
        .RespFault    (RespFault),
        .MemEn        (MemEn),
        .WriteEnable  (WriteEnable),
        .ByteEn       (ByteEn),
        .MemoryAdress (MemoryAdress),
        .InputData    (InputData),
        .MemData      (MemData)
    );

    // Storage model: 16 words, byte-lane writes, combinational read.
    logic [31:0] mem [16];
    logic        preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h8877_6655;
            mem[1] <= 32'hDDCC_BBAA;
        end else if (MemEn && WriteEnable) begin
            for (int b = 0; b < 4; b++)
                if (ByteEn[b]) mem[MemoryAdress[5:2]][8*b +: 8] <= InputData[8*b +: 8];
        end
    end

    assign MemData = MemEn ? mem[MemoryAdress[5:2]] : 32'h0;

    // Beat log: one entry per MemEn cycle.
    int          beats = 0;
    logic [31:0] log_addr [16];
    logic [31:0] log_data [16];
    logic [3:0]  log_be   [16];
    logic        log_we   [16];

    always @(posedge clk) begin
        if (MemEn) begin
            log_addr[beats % 16] <= MemoryAdress;
            log_data[beats % 16] <= InputData;
            log_be[beats % 16]   <= ByteEn;
            log_we[beats % 16]   <= WriteEnable;
            beats <= beats + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request through to its response; hold>0 keeps RespReady low and
    // checks a faulted response stays put meanwhile.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold,
                          output logic [31:0] rd, output logic flt, output int lat,
                          output int fb, output int nb);
        int guard;
        guard = 0;
        while (!ReqReady && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("req_ready", 32'(ReqReady), 32'd1);
        fb          = beats;
        ReqValid    = 1'b1;
        ReqWrite    = wr;
        ReqSize     = sz;
        ReqUnsigned = uns;
        ReqAddr     = addr;
        ReqWData    = wd;
        @(posedge clk); #1;
        ReqValid = 1'b0;
        lat = 1;
        while (!RespValid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("resp_valid", 32'(RespValid), 32'd1);
        rd  = RespData;
        flt = RespFault;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(RespValid), 32'd1);
            check("hold_data", RespData, 32'h0);
            check("hold_fault", 32'(RespFault), 32'd1);
            check("hold_req_ready", 32'(ReqReady), 32'd0);
        end
        RespReady = 1'b1;
        @(posedge clk); #1;
        RespReady = 1'b0;
        nb = beats - fb;
    endtask

    initial begin
        logic [31:0] rd;
        logic        flt;
        int          lat, fb, nb, guard;

        reset_n = 1'b0; preload = 1'b1;
        ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00; ReqUnsigned = 1'b0;
        ReqAddr = 32'h0; ReqWData = 32'h0; RespReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_en", 32'(MemEn), 32'd0);
        check("rst_resp_valid", 32'(RespValid), 32'd0);
        check("rst_byte_en", 32'(ByteEn), 32'd0);
        check("rst_addr", MemoryAdress, 32'h0);
        reset_n = 1'b1; preload = 1'b0;
        @(posedge clk); #1;
        check("rst_req_ready", 32'(ReqReady), 32'd1);

        // Aligned word load
        do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, rd, flt, lat, fb, nb);
        check("lw0_data", rd, 32'h8877_6655);
        check("lw0_fault", 32'(flt), 32'd0);
        check("lw0_latency", 32'(lat), 32'd2);
        check("lw0_beats", 32'(nb), 32'd1);
        check("lw0_addr", log_addr[fb % 16], 32'h0);
        check("lw0_be", 32'(log_be[fb % 16]), 32'hF);
        check("lw0_we", 32'(log_we[fb % 16]), 32'd0);

        // Byte loads at lane 3, signed and unsigned
        do_req(1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 0, rd, flt, lat, fb, nb);
        check("lb3_signed", rd, 32'hFFFF_FF88);
        check("lb3_be", 32'(log_be[fb % 16]), 32'h8);
        do_req(1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 0, rd, flt, lat, fb, nb);
        check("lb3_unsigned", rd, 32'h0000_0088);

        // Half loads: signed upper half, misaligned non-crossing half
        do_req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 0, rd, flt, lat, fb, nb);
        check("lh2_signed", rd, 32'hFFFF_8877);
        do_req(1'b0, 2'b01, 1'b0, 32'h1, 32'h0, 0, rd, flt, lat, fb, nb);
        check("lh1_data", rd, 32'h0000_7766);
        check("lh1_fault", 32'(flt), 32'd0);
        check("lh1_be", 32'(log_be[fb % 16]), 32'h6);

        // Word load crossing a word boundary
        do_req(1'b0, 2'b10, 1'b0, 32'h3, 32'h0, 0, rd, flt, lat, fb, nb);
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
        check("split_data", rd, 32'hCCBB_AA88);
        check("split_fault", 32'(flt), 32'd0);
        check("split_latency", 32'(lat), 32'd3);
        check("split_beats", 32'(nb), 32'd2);
        check("split_addr0", log_addr[fb % 16], 32'h0);
        check("split_be0", 32'(log_be[fb % 16]), 32'h8);
        check("split_addr1", log_addr[(fb + 1) % 16], 32'h4);
        check("split_be1", 32'(log_be[(fb + 1) % 16]), 32'h7);
`else
        check("cross_fault", 32'(flt), 32'd1);
        check("cross_data", rd, 32'h0);
        check("cross_beats", 32'(nb), 32'd0);
        check("cross_latency", 32'(lat), 32'd1);
`endif

        // Half store at lane 2, then reload the word
        do_req(1'b1, 2'b01, 1'b0, 32'h2, 32'hFFFF_1234, 0, rd, flt, lat, fb, nb);
        check("sh_resp_data", rd, 32'h0);
        check("sh_fault", 32'(flt), 32'd0);
        check("sh_beats", 32'(nb), 32'd1);
        check("sh_be", 32'(log_be[fb % 16]), 32'hC);
        check("sh_wdata", log_data[fb % 16], 32'h1234_0000);
        check("sh_we", 32'(log_we[fb % 16]), 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, rd, flt, lat, fb, nb);
        check("sh_reload", rd, 32'h1234_6655);

        // Illegal size, held response
        do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 5, rd, flt, lat, fb, nb);
        check("ill_fault", 32'(flt), 32'd1);
        check("ill_data", rd, 32'h0);
        check("ill_beats", 32'(nb), 32'd0);

        // Range boundary at 4096 bytes
        do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 5, rd, flt, lat, fb, nb);
        check("oor_fault", 32'(flt), 32'd1);
        check("oor_beats", 32'(nb), 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 0, rd, flt, lat, fb, nb);
        check("last_word_fault", 32'(flt), 32'd0);
        check("last_word_beats", 32'(nb), 32'd1);
        check("last_word_addr", log_addr[fb % 16], 32'hFFC);
        do_req(1'b0, 2'b01, 1'b0, 32'hFFE, 32'h0, 0, rd, flt, lat, fb, nb);
        check("last_half_fault", 32'(flt), 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'hFFF_FFFD, 32'h0, 0, rd, flt, lat, fb, nb);
        check("high_addr_fault", 32'(flt), 32'd1);
        check("high_addr_beats", 32'(nb), 32'd0);

        // Reset in the middle of a store
        guard = 0;
        while (!ReqReady && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b10; ReqUnsigned = 1'b0;
        ReqWData = 32'hA1B2_C3D4;
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
        ReqAddr = 32'h3;
        @(posedge clk); #1;
        ReqValid = 1'b0;
        @(posedge clk); #1;
        check("mid_second_beat_addr", MemoryAdress, 32'h4);
`else
        ReqAddr = 32'h0;
        @(posedge clk); #1;
        ReqValid = 1'b0;
`endif
        check("mid_mem_en", 32'(MemEn), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_mem_en", 32'(MemEn), 32'd0);
        check("mid_rst_we", 32'(WriteEnable), 32'd0);
        check("mid_rst_be", 32'(ByteEn), 32'd0);
        check("mid_rst_addr", MemoryAdress, 32'h0);
        check("mid_rst_wdata", InputData, 32'h0);
        check("mid_rst_resp_valid", 32'(RespValid), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rel_req_ready", 32'(ReqReady), 32'd1);
        check("mid_rel_resp_valid", 32'(RespValid), 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 0, rd, flt, lat, fb, nb);
        check("post_rst_word1", rd, 32'hDDCC_BBAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
